// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: feeds one 1-bit ALU slice per cycle, LSB first, carrying
// the ripple carry between cycles and folding SLT/overflow back in at the MSB.
module serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             ready,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             done
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [3:0]       r_ctrl;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_overflow;
  logic             r_done;

  logic             w_ai;
  logic             w_bi;
  logic             w_sum;
  logic             w_cout;
  logic             w_bit;
  logic             w_ovf_raw;
  logic             w_set;
  logic [WIDTH-1:0] w_final;

  // One ALU slice evaluated on the current bit; the adder runs for every op so the
  // MSB carry-in/carry-out are always available for overflow and SLT.
  // NOTE: every always_comb output gets an unconditional default first so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_ai      = r_ctrl[3] ? ~r_a[r_idx] : r_a[r_idx];
    w_bi      = r_ctrl[2] ? ~r_b[r_idx] : r_b[r_idx];
    w_sum     = w_ai ^ w_bi ^ r_carry;
    w_cout    = (w_ai & w_bi) | (w_ai & r_carry) | (w_bi & r_carry);
    w_ovf_raw = r_carry ^ w_cout;
    w_set     = w_sum ^ w_ovf_raw;
    w_bit     = 1'b0;
    case (r_ctrl[1:0])
      2'b00:   w_bit = w_ai & w_bi;
      2'b01:   w_bit = r_a[r_idx] | r_b[r_idx];
      2'b10:   w_bit = w_sum;
      default: w_bit = 1'b0;
    endcase
    w_final            = r_result;
    w_final[WIDTH-1]   = w_bit;
    if (r_ctrl[1:0] == 2'b11) begin
      w_final[0] = w_set;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_a        <= '0;
      r_b        <= '0;
      r_ctrl     <= '0;
      r_idx      <= '0;
      r_carry    <= 1'b0;
      r_result   <= '0;
      r_zero     <= 1'b0;
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a      <= src_a;
            r_b      <= src_b;
            r_ctrl   <= alu_ctrl;
            r_idx    <= '0;
            r_carry  <= alu_ctrl[2];
            r_result <= '0;
            r_state  <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_carry <= w_cout;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST_IDX) begin
            r_result   <= w_final;
            r_zero     <= (w_final == '0);
            r_overflow <= w_ovf_raw & (r_ctrl[1:0] == 2'b10);
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_result[r_idx] <= w_bit;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready    = (r_state != S_RUN);
  assign result   = r_result;
  assign zero     = r_zero;
  assign overflow = r_overflow;
  assign done     = r_done;

endmodule

// File: tb/tb_serial_alu_seq.sv
// Self-checking bench for serial_alu_seq: an arithmetic reference model checked every
// cycle, directed literal cases, handshake/reset corners and a randomized soak.
module tb_serial_alu_seq;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         ready;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         done;

  serial_alu_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .ready    (ready),
    .alu_ctrl (alu_ctrl),
    .src_a    (src_a),
    .src_b    (src_b),
    .result   (result),
    .zero     (zero),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;

  int n_pass   = 0;
  int n_checks = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference ALU computed on whole words with plain arithmetic.
  function automatic void model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic [3:0] c, output logic [W-1:0] r,
                                   output logic ovf);
    logic [W-1:0] ai, bi, sum;
    logic         ov, set;
    ai  = c[3] ? ~a : a;
    bi  = c[2] ? ~b : b;
    sum = ai + bi + W'(c[2]);
    ov  = (ai[W-1] == bi[W-1]) && (sum[W-1] != ai[W-1]);
    set = sum[W-1] ^ ov;
    case (c[1:0])
      2'b00:   r = ai & bi;
      2'b01:   r = a | b;
      2'b10:   r = sum;
      default: r = {{(W-1){1'b0}}, set};
    endcase
    ovf = ov && (c[1:0] == 2'b10);
  endfunction

  // Timing model: an accepted op reports done W cycles after the accepting edge.
  bit           m_valid  = 0;
  int           m_cnt    = 0;
  bit           m_done   = 0;
  logic [W-1:0] m_result = '0;
  bit           m_zero   = 0;
  bit           m_ovf    = 0;
  int           m_dones  = 0;
  logic [W-1:0] p_result;
  logic         p_ovf;
  bit           p_zero;

  always @(posedge clk) begin
    bit was_ready;
    cyc++;
    if (rst) begin
      m_valid  = 1;
      m_cnt    = 0;
      m_done   = 0;
      m_result = '0;
      m_zero   = 0;
      m_ovf    = 0;
    end else if (m_valid) begin
      was_ready = (m_cnt == 0);
      m_done    = 0;
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_done   = 1;
          m_result = p_result;
          m_zero   = p_zero;
          m_ovf    = p_ovf;
          m_dones++;
        end
      end
      if (was_ready && start) begin
        model_op(src_a, src_b, alu_ctrl, p_result, p_ovf);
        p_zero   = (p_result == '0);
        m_cnt    = W;
        m_result = '0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("ready", 64'(ready), 64'(m_cnt == 0));
      check("done", 64'(done), 64'(m_done));
      if (m_cnt == 0) begin
        check("result", 64'(result), 64'(m_result));
        check("zero", 64'(zero), 64'(m_zero));
        check("overflow", 64'(overflow), 64'(m_ovf));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 3 * W; i++) begin
      if (m_cnt == 0) return;
      @(negedge clk);
    end
    check("wait_idle_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_done(output bit seen);
    seen = 0;
    for (int i = 0; i < W + 8; i++) begin
      if (done) begin
        seen = 1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [3:0] c, input logic [W-1:0] er, input logic ez,
                        input logic eo);
    int t_acc;
    bit seen;
    wait_idle();
    start = 1'b1; src_a = a; src_b = b; alu_ctrl = c;
    @(negedge clk);
    t_acc = cyc;
    start = 1'b0; src_a = $urandom; src_b = $urandom; alu_ctrl = 4'($urandom);
    wait_done(seen);
    check({nm, "_timeout"}, 64'(seen), 64'(1));
    if (seen) begin
      check({nm, "_latency"}, 64'(cyc - t_acc + 1), 64'(W + 1));
      check({nm, "_result"}, 64'(result), 64'(er));
      check({nm, "_zero"}, 64'(zero), 64'(ez));
      check({nm, "_ovf"}, 64'(overflow), 64'(eo));
      check({nm, "_model"}, 64'(m_result), 64'(er));
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return {1'b0, {(W-1){1'b1}}};
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return '1;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  n;
    int  t1;
    int  t2;
    bit  seen;
    rst = 1'b1; start = 1'b0; alu_ctrl = '0; src_a = '0; src_b = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(ready), 64'(1));
    check("rst_done", 64'(done), 64'(0));
    check("rst_result", 64'(result), 64'(0));
    check("rst_zero", 64'(zero), 64'(0));
    check("rst_ovf", 64'(overflow), 64'(0));
    rst = 1'b0;

    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 4'b0010, 32'h8000_0000, 1'b0, 1'b1);
    run_op("sub_zero", 32'h0000_0005, 32'h0000_0005, 4'b0110, 32'h0000_0000, 1'b1, 1'b0);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 4'b0110, 32'h7FFF_FFFF, 1'b0, 1'b1);
    run_op("slt_neg", 32'hFFFF_FFFD, 32'h0000_0002, 4'b0111, 32'h0000_0001, 1'b0, 1'b0);
    run_op("slt_iovf", 32'h8000_0000, 32'h0000_0001, 4'b0111, 32'h0000_0001, 1'b0, 1'b0);
    run_op("slt_pos", 32'h0000_0002, 32'hFFFF_FFFD, 4'b0111, 32'h0000_0000, 1'b1, 1'b0);
    run_op("nor", 32'h0F0F_0000, 32'h00FF_00FF, 4'b1100, 32'hF000_FF00, 1'b0, 1'b0);
    run_op("and", 32'h0F0F_0000, 32'h00FF_00FF, 4'b0000, 32'h000F_0000, 1'b0, 1'b0);
    run_op("or", 32'h0F0F_0000, 32'h00FF_00FF, 4'b0001, 32'h0FFF_00FF, 1'b0, 1'b0);

    // A start pulse during RUN must be ignored.
    wait_idle();
    start = 1'b1; src_a = 32'd10; src_b = 32'd20; alu_ctrl = 4'b0010;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; src_a = 32'd99; src_b = 32'd1; alu_ctrl = 4'b0110;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    repeat (W + 20) begin
      if (done) begin
        n++;
        check("midrun_result", 64'(result), 64'(30));
      end
      @(negedge clk);
    end
    check("midrun_done_count", 64'(n), 64'(1));

    // Reset while processing bit 10 aborts without a done pulse.
    wait_idle();
    start = 1'b1; src_a = 32'd5; src_b = 32'd6; alu_ctrl = 4'b0010;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 64'(ready), 64'(1));
    check("abort_result", 64'(result), 64'(0));
    check("abort_done", 64'(done), 64'(0));
    n = 0;
    repeat (W + 10) begin
      @(negedge clk);
      if (done) n++;
    end
    check("abort_no_done", 64'(n), 64'(0));

    // Back-to-back: start held from the ADD accept through its DONE cycle.
    wait_idle();
    start = 1'b1; src_a = 32'd3; src_b = 32'd4; alu_ctrl = 4'b0010;
    @(negedge clk);
    src_a = 32'd3; src_b = 32'd4; alu_ctrl = 4'b0110;
    wait_done(seen);
    t1 = cyc;
    check("b2b_first_seen", 64'(seen), 64'(1));
    check("b2b_first_result", 64'(result), 64'(7));
    @(negedge clk);
    start = 1'b0;
    wait_done(seen);
    t2 = cyc;
    check("b2b_second_seen", 64'(seen), 64'(1));
    check("b2b_second_result", 64'(result), 64'hFFFF_FFFF);
    check("b2b_spacing", 64'(t2 - t1), 64'(W + 1));

    // Randomized soak; the per-cycle compare checks every output against the model.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rst      = ($urandom_range(0, 499) == 0);
      start    = ($urandom_range(0, 2) == 0);
      src_a    = pick();
      src_b    = pick();
      alu_ctrl = 4'($urandom);
    end
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    repeat (W + 4) @(negedge clk);
    check("random_ops_completed", 64'(m_dones > 40), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Bit-serial 32-bit ALU sequencer that drives one 1-bit ALU slice per cycle, LSB first.
- Carries the ripple carry between cycles and captures set/overflow at the MSB.
- Applies the SLT feedback to bit 0 and returns the full result with zero/overflow flags.
- Sits directly upstream of the per-bit ALU slices as their operand/carry feeder; used where area matters more than latency.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when ready=1.
- ready  output  1  high in IDLE and DONE; low in RUN.
- alu_ctrl  input  4  {a_invert, b_invert, operation[1:0]}; latched on accept.
- src_a  input  WIDTH  operand A; latched on accept.
- src_b  input  WIDTH  operand B; latched on accept.
- result  output  WIDTH  registered result; held until the next accept.
- zero  output  1  result == 0; valid with done, held.
- overflow  output  1  signed overflow, only when operation==2'b10; else 0.
- done  output  1  one-cycle pulse when result, zero and overflow are valid.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, result=0, zero=0, overflow=0, done=0, bit index=0, carry=0. ready=1 after reset.
- States:
  - IDLE: start=1 latches operands and ctrl, sets idx=0, carry=b_invert, clears result, goes to RUN.
  - RUN: each cycle processes bit idx (see per-bit function); idx==WIDTH-1 goes to DONE.
  - DONE: done=1 for exactly this cycle. start=1 here is accepted, same as in IDLE (back-to-back); otherwise go to IDLE.
- Per-bit function, with ai = a_invert ? ~a[idx] : a[idx] and bi likewise:
  - 00: ai & bi.
  - 01: a[idx] | b[idx]; inversion bits are ignored.
  - 10: ai ^ bi ^ carry; carry <= majority(ai, bi, carry).
  - 11: 0 for every bit; the adder still runs and updates carry.
- At idx==WIDTH-1:
  - cin_msb = current carry; cout = majority(ai, bi, cin_msb).
  - ovf_raw = cin_msb ^ cout; set = sum ^ ovf_raw.
  - overflow <= ovf_raw & (operation==10).
  - If operation==11, result[0] is forced to set on entry to DONE.
- zero is registered on entry to DONE from the final result value, including the set-bit fix.
- Latency: accept at cycle T; done=1 at T+WIDTH+1; ready low for cycles T+1 .. T+WIDTH.
- Control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100. All 16 codes are legal and follow the per-bit rule.
- Boundaries:
  - start while ready=0 is ignored; no queuing.
  - rst mid-RUN aborts: next cycle shows the reset values and no done pulse.
  - src_a/src_b/alu_ctrl changes during RUN have no effect.
  - result bits are written in place as computed; result is only architecturally valid on done.
  - The carry register is not reset between ops; it is reloaded on accept.

Test Plan:
1. ADD 0x7FFFFFFF + 0x00000001, ctrl 0010 -> done exactly 33 cycles after accept; result 0x80000000, overflow 1, zero 0.
2. SUB 0x00000005 - 0x00000005, ctrl 0110 -> result 0x00000000, zero 1, overflow 0. SUB 0x80000000 - 0x00000001 -> result 0x7FFFFFFF, overflow 1.
3. SLT, ctrl 0111:
   - 0xFFFFFFFD vs 0x00000002 -> result 0x00000001.
   - 0x80000000 vs 0x00000001 (internal overflow) -> result 0x00000001, overflow 0.
   - 0x00000002 vs 0xFFFFFFFD -> result 0x00000000, zero 1.
4. Logic ops:
   - NOR 0x0F0F0000, 0x00FF00FF, ctrl 1100 -> 0xF000FF00.
   - AND same operands, ctrl 0000 -> 0x000F0000.
   - OR, ctrl 0001 -> 0x0FFF00FF.
5. Handshake and reset:
   - start pulsed mid-RUN -> ignored; exactly one done.
   - rst asserted at idx 10 -> next cycle ready 1, result 0, done 0, and no later done pulse.
6. Back-to-back: ADD 3+4 then, with start held through the DONE cycle, SUB 3-4 -> done pulses 33 cycles apart; results 0x00000007 then 0xFFFFFFFF, each result stable until the following accept.
